// File: rtl/runway_gate_tracker_if.sv
// Allocation command / acknowledge handshake between the gate controller and the tracker.
interface runway_gate_tracker_if;
  logic       alloc_valid;
  logic       alloc_ready;
  logic       alloc_kind;
  logic [1:0] alloc_runway;
  logic [2:0] alloc_gate;
  logic       ack_valid;
  logic [1:0] ack_status;

  modport master (
    output alloc_valid, alloc_kind, alloc_runway, alloc_gate,
    input  alloc_ready, ack_valid, ack_status
  );

  modport slave (
    input  alloc_valid, alloc_kind, alloc_runway, alloc_gate,
    output alloc_ready, ack_valid, ack_status
  );
endinterface

// File: rtl/runway_gate_tracker.sv
// Tracks runway/gate occupancy: checks landing/takeoff grants, acks each one,
// and times out runway occupancy after RUNWAY_HOLD cycles.
module runway_gate_tracker #(
  parameter logic [3:0] RUNWAY_HOLD = 4'd8
) (
  input  logic                        clk,
  input  logic                        reset,
  runway_gate_tracker_if.slave        alloc,
  output logic [3:0]                  runway_busy,
  output logic [7:0]                  gate_busy,
  output logic [7:0]                  accept_count
);

  localparam int unsigned NUM_RUNWAYS = 4;
  localparam int unsigned NUM_GATES   = 8;
  localparam int unsigned HOLD_W      = 4;

  localparam logic [1:0] STATUS_OK       = 2'b00;
  localparam logic [1:0] STATUS_RUNWAY   = 2'b01;
  localparam logic [1:0] STATUS_GATE     = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t state, state_next;

  logic                       cmd_kind;
  logic [1:0]                 cmd_runway;
  logic [2:0]                 cmd_gate;
  logic                       ready_q;
  logic                       ack_valid_q;
  logic [1:0]                 status_q;
  logic [HOLD_W-1:0]          hold_cnt [NUM_RUNWAYS];

  logic                       accept_c;
  logic                       check_ok_c;
  logic [1:0]                 status_next_c;
  logic [NUM_RUNWAYS-1:0]     runway_set_c;
  logic [NUM_GATES-1:0]       gate_next_c;

  assign alloc.alloc_ready = ready_q;
  assign alloc.ack_valid   = ack_valid_q;
  assign alloc.ack_status  = status_q;

  // Next-state and CHECK-cycle evaluation against the bitmaps registered at cycle start.
  always_comb begin
    state_next    = state;
    accept_c      = 1'b0;
    check_ok_c    = 1'b0;
    status_next_c = status_q;
    runway_set_c  = '0;
    gate_next_c   = gate_busy;
    case (state)
      IDLE: begin
        if (alloc.alloc_valid && ready_q) begin
          accept_c   = 1'b1;
          state_next = CHECK;
        end
      end
      CHECK: begin
        state_next = ACK;
        if (runway_busy[cmd_runway]) begin
          status_next_c = STATUS_RUNWAY;
        end else if (gate_busy[cmd_gate] == ~cmd_kind) begin
          status_next_c = STATUS_GATE;
        end else begin
          status_next_c            = STATUS_OK;
          check_ok_c               = 1'b1;
          runway_set_c[cmd_runway] = 1'b1;
          gate_next_c[cmd_gate]    = ~cmd_kind;
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ready_q     <= 1'b1;
      ack_valid_q <= 1'b0;
      status_q    <= STATUS_OK;
    end else begin
      state       <= state_next;
      ready_q     <= (state_next == IDLE);
      ack_valid_q <= (state_next == ACK);
      status_q    <= status_next_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_kind   <= 1'b0;
      cmd_runway <= '0;
      cmd_gate   <= '0;
    end else if (accept_c) begin
      cmd_kind   <= alloc.alloc_kind;
      cmd_runway <= alloc.alloc_runway;
      cmd_gate   <= alloc.alloc_gate;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gate_busy    <= '0;
      accept_count <= '0;
    end else begin
      gate_busy    <= gate_next_c;
      accept_count <= accept_count + 8'(check_ok_c);
    end
  end

  // Per-runway hold timers; a new grant outranks expiry on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      runway_busy <= '0;
      for (int i = 0; i < NUM_RUNWAYS; i++) hold_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_RUNWAYS; i++) begin
        if (runway_set_c[i]) begin
          runway_busy[i] <= 1'b1;
          hold_cnt[i]    <= RUNWAY_HOLD;
        end else if (runway_busy[i]) begin
          hold_cnt[i] <= hold_cnt[i] - HOLD_W'(1);
          if (hold_cnt[i] == HOLD_W'(1)) runway_busy[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/runway_gate_tracker.md
RUNWAY_GATE_TRACKER -- requirements
Module: runway_gate_tracker

Interface
REQ-001 The block SHALL have parameter RUNWAY_HOLD, default 4'd8: cycles a runway stays occupied after an accepted grant (legal 1..15).
REQ-002 The block SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have port alloc_valid, input, 1: allocation command from the controller is present.
REQ-005 The block SHALL have port alloc_ready, output, 1: block can accept a command this cycle.
REQ-006 The block SHALL have port alloc_kind, input, 1: 0 = landing, 1 = takeoff.
REQ-007 The block SHALL have port alloc_runway, input, 2: runway being granted.
REQ-008 The block SHALL have port alloc_gate, input, 3: gate being granted (landing) or vacated (takeoff).
REQ-009 The block SHALL have port runway_busy, output, 4: per-runway occupancy bitmap.
REQ-010 The block SHALL have port gate_busy, output, 8: per-gate occupancy bitmap.
REQ-011 The block SHALL have port ack_valid, output, 1: one-cycle pulse reporting a command result.
REQ-012 The block SHALL have port ack_status, output, 2: 00 ok, 01 runway conflict, 10 gate conflict; valid only with ack_valid.
REQ-013 The block SHALL have port accept_count, output, 8: number of commands acknowledged ok.

Function
REQ-014 The FSM SHALL have states IDLE, CHECK, ACK; alloc_ready = 1 only in IDLE.
REQ-015 A command SHALL be accepted when alloc_valid && alloc_ready; alloc_kind/runway/gate captured in that cycle; IDLE -> CHECK.
REQ-016 CHECK SHALL last one cycle, evaluate captured command against current bitmaps, register status, apply occupancy updates if ok, then go to ACK.
REQ-017 ACK SHALL assert ack_valid for exactly one cycle with the registered status, then go to IDLE; accept at edge N gives ack_valid high in cycle N+2.
REQ-018 Inputs SHALL be ignored while alloc_ready = 0; back-to-back commands are accepted at most once per 3 cycles.
REQ-019 Landing ok condition: runway_busy[runway] = 0 and gate_busy[gate] = 0; on ok, set both bits.
REQ-020 Takeoff ok condition: runway_busy[runway] = 0 and gate_busy[gate] = 1; on ok, set runway bit, clear gate bit.
REQ-021 Failure status SHALL be 01 if runway check fails (priority), else 10 if gate check fails; on failure no bitmap or counter changes.
REQ-022 Each runway SHALL own a 4-bit down-counter loaded with RUNWAY_HOLD when its bit is set; while busy it decrements once per cycle; busy bit clears on the edge where the counter goes 1 -> 0.
REQ-023 If a runway expires and is re-occupied on the same edge, occupancy SHALL win: bit stays 1, counter reloads to RUNWAY_HOLD.
REQ-024 CHECK SHALL evaluate the runway bit as registered at the start of the CHECK cycle (expiry on that edge is not seen).
REQ-025 Gate bits SHALL change only via REQ-019/REQ-020; no timeout.
REQ-026 accept_count SHALL increment by 1 on each ok result, wrapping 255 -> 0.
REQ-027 Multiple runways SHALL count down independently and concurrently.

Reset
REQ-028 On reset high at a clock edge: state IDLE, alloc_ready = 1, ack_valid = 0, ack_status = 00, runway_busy = 0, gate_busy = 0, all runway counters 0, accept_count = 0.
REQ-029 Reset SHALL take priority over any in-progress command; a command in CHECK/ACK is discarded with no ack pulse.

Verification
REQ-030 Landing kind=0, runway=2, gate=3 from reset -> ack_valid at N+2 status 00; runway_busy = 0100, gate_busy = 0000_1000, accept_count = 1.
REQ-031 After REQ-030, landing runway=2 gate=5 while runway 2 busy -> status 01; bitmaps and accept_count unchanged.
REQ-032 Takeoff runway=1 gate=3 after runway 2 expiry -> status 00; gate_busy = 0, runway_busy = 0010; takeoff runway=0 gate=6 (gate free) -> status 10.
REQ-033 RUNWAY_HOLD = 8: runway_busy[2] high for exactly 8 cycles after the CHECK edge that set it, then 0; re-grant on the expiry edge keeps bit high and reloads 8.
REQ-034 alloc_valid held high continuously with ok commands -> alloc_ready low 2 of every 3 cycles, one ack per command, no lost or duplicated acks.
REQ-035 Reset asserted in CHECK cycle -> no ack_valid pulse; all outputs at REQ-028 values next cycle; accept_count 255 + one ok -> 0.
